// File: rtl/param_full_adder_pkg.sv
// Shared constants for the parameterised ripple-carry adder.
// Holds the default operand width and the upper bound used by the elaboration range check.
package param_adder_pkg;

  localparam int DEFAULT_WIDTH = 3;
  localparam int MAX_WIDTH     = 32;

endpackage

// File: rtl/param_full_adder_if.sv
// Operand/result bundle for param_full_adder.
// The master modport drives the operands; the slave modport is the adder side.
interface param_full_adder_if
  import param_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic [WIDTH:0]   o_result;
  logic             o_valid;

  modport master (
    output i_add_term1,
    output i_add_term2,
    input  o_result,
    input  o_valid
  );

  modport slave (
    input  i_add_term1,
    input  i_add_term2,
    output o_result,
    output o_valid
  );

endinterface

// File: rtl/param_full_adder_bit.sv
// One-bit full-adder cell, the building block of the ripple chain.
// Purely combinational; X/Z on any input propagates to the outputs.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign s       = a_xor_b ^ cin;
  assign cout    = (a & b) | (cin & a_xor_b);

endmodule

// File: rtl/param_full_adder.sv
// Unsigned WIDTH-bit ripple-carry adder with a registered WIDTH+1-bit result.
// Carry-out of the last cell becomes the result MSB; o_valid rises on the first edge out of reset.
module param_full_adder
  import param_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              i_clk,
  input logic              i_rst_n,
  param_full_adder_if.slave bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $fatal(1, "param_full_adder: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;

  assign carry[0] = 1'b0;

  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    full_adder_bit u_fa (
      .a    (bus.i_add_term1[k]),
      .b    (bus.i_add_term2[k]),
      .cin  (carry[k]),
      .s    (sum_bits[k]),
      .cout (carry[k+1])
    );
  end

  logic [WIDTH:0] result_d, result_q;
  logic           valid_d,  valid_q;

  always_comb begin
    result_d = {carry[WIDTH], sum_bits};
    valid_d  = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_result = result_q;
  assign bus.o_valid  = valid_q;

endmodule

// File: tb/tb_param_full_adder.sv
// Directed bench for param_full_adder at WIDTH=3, 1 and 8.
// Operands change 1 ns after a rising edge; outputs are sampled 1 ns after the following edge.
module tb_param_full_adder;

  logic i_clk;
  logic i_rst_n;

  int n_checks = 0;
  int n_errors = 0;

  param_full_adder_if #(.WIDTH(3)) bus3 ();
  param_full_adder_if #(.WIDTH(1)) bus1 ();
  param_full_adder_if #(.WIDTH(8)) bus8 ();

  param_full_adder #(.WIDTH(3)) u_dut3 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus3));
  param_full_adder #(.WIDTH(1)) u_dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus1));
  param_full_adder #(.WIDTH(8)) u_dut8 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus8));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] exp;
    string      tag;
  } vec3_t;

  vec3_t vecs[9] = '{
    '{3'd0, 3'd0, 4'b0000, "0+0"},
    '{3'd1, 3'd0, 4'b0001, "1+0"},
    '{3'd1, 3'd1, 4'b0010, "1+1"},
    '{3'd2, 3'd0, 4'b0010, "2+0"},
    '{3'd0, 3'd2, 4'b0010, "0+2"},
    '{3'd2, 3'd2, 4'b0100, "2+2"},
    '{3'd4, 3'd4, 4'b1000, "4+4"},
    '{3'd7, 3'd7, 4'b1110, "7+7"},
    '{3'd7, 3'd1, 4'b1000, "7+1"}
  };

  initial begin
    bus3.i_add_term1 = 3'b101;
    bus3.i_add_term2 = 3'b011;
    bus1.i_add_term1 = 1'b1;
    bus1.i_add_term2 = 1'b1;
    bus8.i_add_term1 = 8'd255;
    bus8.i_add_term2 = 8'd255;
    i_rst_n = 1'b0;
    #1;

    step();
    step();
    check("reset_result", 64'(bus3.o_result), 64'h0);
    check("reset_valid",  64'(bus3.o_valid),  64'h0);
    check("reset_valid_w8", 64'(bus8.o_valid), 64'h0);

    i_rst_n = 1'b1;
    step();
    check("release_result", 64'(bus3.o_result), 64'b1000);
    check("release_valid",  64'(bus3.o_valid),  64'h1);
    check("w1_1p1",         64'(bus1.o_result), 64'b10);
    check("w8_255p255",     64'(bus8.o_result), 64'h1FE);

    bus8.i_add_term1 = 8'd128;
    bus8.i_add_term2 = 8'd127;
    bus1.i_add_term1 = 1'b1;
    bus1.i_add_term2 = 1'b0;
    step();
    check("w8_128p127", 64'(bus8.o_result), 64'h0FF);
    check("w1_1p0",     64'(bus1.o_result), 64'b01);

    foreach (vecs[i]) begin
      bus3.i_add_term1 = vecs[i].a;
      bus3.i_add_term2 = vecs[i].b;
      step();
      check(vecs[i].tag, 64'(bus3.o_result), 64'(vecs[i].exp));
    end

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        bus3.i_add_term1 = 3'(a);
        bus3.i_add_term2 = 3'(b);
        step();
        check($sformatf("exh_%0d+%0d", a, b), 64'(bus3.o_result), 64'(a + b));
        check("exh_valid", 64'(bus3.o_valid), 64'h1);
      end
    end

    bus3.i_add_term1 = 3'd7;
    bus3.i_add_term2 = 3'd7;
    step();
    check("pre_rst_7p7", 64'(bus3.o_result), 64'b1110);
    i_rst_n = 1'b0;
    step();
    check("mid_rst_result", 64'(bus3.o_result), 64'h0);
    check("mid_rst_valid",  64'(bus3.o_valid),  64'h0);
    i_rst_n = 1'b1;
    step();
    check("post_rst_result", 64'(bus3.o_result), 64'b1110);
    check("post_rst_valid",  64'(bus3.o_valid),  64'h1);

    step();
    check("hold_const", 64'(bus3.o_result), 64'b1110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
